// File: rtl/pwm_multi_gen_if.sv
// Control/status bundle between the register block and the multi-channel PWM generator.
// master = register/control side, slave = generator.
interface pwm_multi_gen_if #(
    parameter int unsigned CH = 4,
    parameter int unsigned CW = 8
);
    logic                 en;
    logic [2:0]           freq;
    logic                 mode;
    logic [CH-1:0]        pol;
    logic [CH*CW-1:0]     duty_i;
    logic                 duty_ld;
    logic [CH-1:0]        pwm_o;
    logic [CW-1:0]        cnt_o;
    logic                 period_tick;
    logic                 ld_pending;

    modport master (
        output en, freq, mode, pol, duty_i, duty_ld,
        input  pwm_o, cnt_o, period_tick, ld_pending
    );

    modport slave (
        input  en, freq, mode, pol, duty_i, duty_ld,
        output pwm_o, cnt_o, period_tick, ld_pending
    );
endinterface

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: shared prescaler and period counter (edge or centre aligned),
// per-channel double-buffered duty and polarity, period-boundary tick.
module pwm_multi_gen #(
    parameter int unsigned CH      = 4,
    parameter int unsigned CW      = 8,
    parameter int unsigned DIV_MAX = 10
) (
    input  logic           clk_100m,
    input  logic           rst_n,
    pwm_multi_gen_if.slave bus
);
    localparam int unsigned PSW     = (DIV_MAX > 0) ? DIV_MAX : 1;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

    logic [PSW-1:0]   ps_cnt;
    logic [PSW-1:0]   ps_term_c;
    logic [2:0]       freq_q;
    logic             mode_q;
    logic             en_q;
    dir_t             dir;
    logic [CW-1:0]    cnt;
    logic [CH*CW-1:0] duty_pend;
    logic [CH*CW-1:0] duty_act;
    logic             ld_pend;
    logic             tick;
    logic [CH-1:0]    pwm;
    logic             en_rise_c;
    logic             step_c;
    logic             bnd_c;
    logic             reload_c;

    // Prescaler terminal count; rates at or above DIV_MAX step every cycle.
    always_comb begin
        ps_term_c = '0;
        if (32'(freq_q) < DIV_MAX)
            ps_term_c = PSW'((33'd1 << (DIV_MAX - 32'(freq_q))) - 33'd1);
    end

    assign en_rise_c = bus.en && !en_q;
    assign step_c    = bus.en && en_q && (ps_cnt >= ps_term_c);
    assign bnd_c     = step_c && (mode_q ? ((dir == DIR_DOWN) && (cnt == CW'(1)))
                                         : (cnt == CNT_MAX));
    assign reload_c  = bnd_c || en_rise_c;

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt    <= '0;
            freq_q    <= '0;
            mode_q    <= 1'b0;
            en_q      <= 1'b0;
            dir       <= DIR_UP;
            cnt       <= '0;
            duty_pend <= '0;
            duty_act  <= '0;
            ld_pend   <= 1'b0;
            tick      <= 1'b0;
            pwm       <= '0;
        end else begin
            en_q <= bus.en;
            tick <= bnd_c;

            // Counting restarts from zero whenever the block is idle or just enabled.
            if (!bus.en || en_rise_c) begin
                ps_cnt <= '0;
                cnt    <= '0;
                dir    <= DIR_UP;
            end else if (step_c) begin
                ps_cnt <= '0;
                if (bnd_c) begin
                    cnt <= '0;
                    dir <= DIR_UP;
                end else if (!mode_q) begin
                    cnt <= cnt + CW'(1);
                end else if (dir == DIR_UP) begin
                    if (cnt == CNT_MAX) begin
                        dir <= DIR_DOWN;
                        cnt <= cnt - CW'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end else begin
                ps_cnt <= ps_cnt + PSW'(1);
            end

            if (reload_c) begin
                freq_q <= bus.freq;
                mode_q <= bus.mode;
                if (ld_pend)
                    duty_act <= duty_pend;
            end

            // A load coincident with a transfer keeps the flag set for the next boundary.
            if (bus.duty_ld) begin
                duty_pend <= bus.duty_i;
                ld_pend   <= 1'b1;
            end else if (reload_c) begin
                ld_pend   <= 1'b0;
            end

            for (int unsigned k = 0; k < CH; k++)
                pwm[k] <= (bus.en && (cnt < duty_act[k*CW +: CW])) ^ bus.pol[k];
        end
    end

    assign bus.pwm_o       = pwm;
    assign bus.cnt_o       = cnt;
    assign bus.period_tick = tick;
    assign bus.ld_pending  = ld_pend;
endmodule

// File: tb/tb_pwm_multi_gen.sv
// Scoreboard bench for pwm_multi_gen: per-period length and per-channel high time are
// measured between ticks and compared against queued expectations.
module tb_pwm_multi_gen;
    logic clk_100m = 1'b0;
    logic rst_n;

    always #5 clk_100m = ~clk_100m;

    pwm_multi_gen_if #(.CH(4), .CW(8)) bus ();

    pwm_multi_gen #(.CH(4), .CW(8), .DIV_MAX(2)) dut (
        .clk_100m (clk_100m),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    typedef struct {
        int per;
        int h [4];
        int lastc;
    } exp_t;

    exp_t exp_q [$];
    exp_t e;
    int   n_chk = 0;
    int   n_err = 0;
    bit   sync  = 1'b0;
    bit   synced = 1'b0;
    int   win = 0;
    int   hacc [4];
    int   prev_cnt = 0;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int per, input int h0, input int h1, input int h2,
                        input int h3, input int lastc);
        exp_t x;
        x.per = per;
        x.h[0] = h0; x.h[1] = h1; x.h[2] = h2; x.h[3] = h3;
        x.lastc = lastc;
        exp_q.push_back(x);
    endtask

    task automatic ld(input int d0, input int d1, input int d2, input int d3);
        bus.duty_i  = {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
        bus.duty_ld = 1'b1;
        @(negedge clk_100m);
        bus.duty_ld = 1'b0;
    endtask

    task automatic wait_size(input int n, input string name);
        int b = 0;
        while (exp_q.size() > n && b < 4000) begin
            @(negedge clk_100m);
            b++;
        end
        if (exp_q.size() > n) begin
            n_chk++; n_err++;
            $display("FAIL %s_timeout: queue %0d, expected <= %0d", name, exp_q.size(), n);
        end
    endtask

    task automatic wait_tick(input string name);
        int b = 0;
        do begin
            @(negedge clk_100m);
            b++;
        end while (!bus.period_tick && b < 4000);
        if (!bus.period_tick) begin
            n_chk++; n_err++;
            $display("FAIL %s_timeout: tick %0d, expected 1", name, bus.period_tick);
        end
    endtask

    task automatic wait_cnt(input int v, input string name);
        int b = 0;
        while (int'(bus.cnt_o) != v && b < 4000) begin
            @(negedge clk_100m);
            b++;
        end
        if (int'(bus.cnt_o) != v) begin
            n_chk++; n_err++;
            $display("FAIL %s_timeout: cnt %0d, expected %0d", name, bus.cnt_o, v);
        end
    endtask

    // Monitor: a window runs from the cycle after one tick up to and including the next.
    always @(negedge clk_100m) begin
        if (rst_n) begin
            win++;
            for (int k = 0; k < 4; k++) hacc[k] += int'(bus.pwm_o[k]);
            if (bus.period_tick) begin
                check("tick_cnt0", int'(bus.cnt_o), 0);
                if (sync && synced) begin
                    if (exp_q.size() == 0) begin
                        n_chk++; n_err++;
                        $display("FAIL unexpected_tick: got 1 tick, expected 0 queued");
                    end else begin
                        e = exp_q.pop_front();
                        check("period", win, e.per);
                        for (int k = 0; k < 4; k++)
                            check($sformatf("high_ch%0d", k), hacc[k], e.h[k]);
                        check("last_cnt", prev_cnt, e.lastc);
                    end
                end
                synced = sync;
                win = 0;
                for (int k = 0; k < 4; k++) hacc[k] = 0;
            end
            prev_cnt = int'(bus.cnt_o);
        end
        if (!sync) synced = 1'b0;
    end

    initial begin
        int bad;
        for (int k = 0; k < 4; k++) hacc[k] = 0;
        rst_n       = 1'b1;
        bus.en      = 1'b0;
        bus.freq    = 3'd0;
        bus.mode    = 1'b0;
        bus.pol     = 4'b0000;
        bus.duty_i  = '0;
        bus.duty_ld = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk_100m);
        check("rst_pwm", int'(bus.pwm_o), 0);
        check("rst_cnt", int'(bus.cnt_o), 0);
        check("rst_tick", int'(bus.period_tick), 0);
        check("rst_ldp", int'(bus.ld_pending), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_100m);

        // Load while disabled, then enable: transfer is immediate on the rising edge of en.
        ld(64, 1, 255, 0);
        check("ldp_while_off", int'(bus.ld_pending), 1);
        bus.en = 1'b1;
        sync = 1'b1;
        for (int f = 0; f < 4; f++) begin
            int d;
            d = (f >= 2) ? 1 : (4 >> f);
            repeat (2) push(256 * d, 64 * d, d, 255 * d, 0, 255);
        end
        @(negedge clk_100m);
        check("ldp_en_rise", int'(bus.ld_pending), 0);

        // Frequency sweep: each change lands mid-period and applies after the next tick.
        for (int f = 1; f < 4; f++) begin
            wait_size(8 - (2 * f - 1), "sweep");
            repeat (5) @(negedge clk_100m);
            bus.freq = 3'(f);
        end
        wait_size(0, "sweep_end");
        sync = 1'b0;

        // Double buffer at one step per clock.
        repeat (10) @(negedge clk_100m);
        ld(32, 1, 255, 0);
        sync = 1'b1;
        push(256, 32, 1, 255, 0, 255);
        push(256, 200, 1, 255, 0, 255);
        push(256, 150, 1, 255, 0, 255);
        push(256, 100, 1, 255, 0, 255);
        wait_tick("db_base");
        repeat (100) @(negedge clk_100m);
        ld(200, 1, 255, 0);
        check("ldp_mid", int'(bus.ld_pending), 1);
        wait_size(3, "db0");
        check("ldp_after_tick", int'(bus.ld_pending), 0);
        repeat (50) @(negedge clk_100m);
        ld(150, 1, 255, 0);
        wait_cnt(255, "db_last");
        ld(100, 1, 255, 0);
        wait_size(2, "db1");
        check("ldp_coincident", int'(bus.ld_pending), 1);
        wait_size(1, "db2");
        check("ldp_deferred", int'(bus.ld_pending), 0);
        wait_size(0, "db_end");
        sync = 1'b0;

        // Centre-aligned: 510-clock period, tick on the 1 -> 0 step.
        repeat (10) @(negedge clk_100m);
        bus.mode = 1'b1;
        ld(100, 1, 255, 0);
        sync = 1'b1;
        repeat (2) push(510, 199, 1, 509, 0, 1);
        wait_size(0, "centre");
        sync = 1'b0;

        // Polarity and duty extremes, edge-aligned.
        repeat (10) @(negedge clk_100m);
        bus.mode = 1'b0;
        ld(0, 1, 255, 128);
        bus.pol = 4'b0010;
        sync = 1'b1;
        repeat (2) push(256, 0, 255, 255, 128, 255);
        wait_size(0, "pol");
        sync = 1'b0;

        bus.en = 1'b0;
        repeat (3) @(negedge clk_100m);
        check("off_pwm_pol", int'(bus.pwm_o), 2);
        check("off_cnt", int'(bus.cnt_o), 0);
        check("off_tick", int'(bus.period_tick), 0);

        // Asynchronous reset mid-period with a load pending.
        bus.en = 1'b1;
        @(negedge clk_100m);
        ld(50, 1, 255, 128);
        wait_cnt(77, "rst_wait");
        check("ldp_before_rst", int'(bus.ld_pending), 1);
        check("pwm_before_rst", int'(bus.pwm_o), 4'b1110);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pwm", int'(bus.pwm_o), 0);
        check("arst_cnt", int'(bus.cnt_o), 0);
        check("arst_tick", int'(bus.period_tick), 0);
        check("arst_ldp", int'(bus.ld_pending), 0);
        bus.duty_i = '0;
        bus.pol    = 4'b0000;
        @(negedge clk_100m);
        rst_n = 1'b1;
        bad = 0;
        repeat (600) begin
            @(negedge clk_100m);
            if (bus.pwm_o != 4'b0000) bad++;
        end
        check("idle_after_rst", bad, 0);
        check("idle_ldp", int'(bus.ld_pending), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pwm_multi_gen.md
Name: pwm_multi_gen

Overview:
- Parametrised multi-channel successor to the single-channel PWM generator.
- Shared prescaler with a 3-bit frequency select, as in the current block.
- Shared period counter, exported as cnt_o; it plays the role data_o plays today.
- Up to CH independent PWM outputs, each with double-buffered duty, per-channel polarity, edge- or centre-aligned mode, and a period-boundary tick.
- Sits between the control/register logic and the pad drivers in the clk_100m domain.

Parameters:
CH, 4, number of PWM channels (1..16)
CW, 8, period counter / duty width in bits
DIV_MAX, 10, prescaler exponent; step divide = 2^(DIV_MAX - freq)

Ports:
clk_100m  input  1  system clock, 100 MHz
rst_n  input  1  asynchronous active-low reset
en  input  1  global run enable
freq  input  3  step-rate select; larger value = faster
mode  input  1  0 = edge-aligned, 1 = centre-aligned
pol  input  CH  per-channel output inversion
duty_i  input  CH*CW  packed duty values; channel k = duty_i[k*CW +: CW]
duty_ld  input  1  one-cycle strobe capturing duty_i into pending registers
pwm_o  output  CH  registered PWM outputs
cnt_o  output  CW  current period counter value
period_tick  output  1  one-cycle pulse at each period boundary
ld_pending  output  1  high while captured duty is waiting for a boundary

Behaviour:
- Reset (async assert, sync release), all registers zero:
  - pwm_o=0, cnt_o=0, period_tick=0, ld_pending=0.
  - Pending and active duty = 0; dir = up; freq_q/mode_q = 0.
- Prescaler:
  - ps_cnt counts clk_100m cycles; step fires when ps_cnt == 2^(DIV_MAX-freq_q)-1, then ps_cnt clears.
  - If freq_q >= DIV_MAX, step fires every cycle.
  - freq_q and mode_q reload from freq/mode only at a period boundary, and on en rising.
- Edge mode (mode_q=0):
  - cnt counts 0..2^CW-1 up on each step and wraps to 0.
  - Boundary = the step that wraps 2^CW-1 -> 0. Period = 2^CW steps.
- Centre mode (mode_q=1):
  - cnt counts up to 2^CW-1, then down to 0, then up again. No repeated endpoint values.
  - Boundary = the step that takes cnt from 1 to 0 while counting down. Period = 2*(2^CW-1) steps.
- Boundary actions, all in the same cycle:
  - period_tick=1 for exactly one clk_100m cycle.
  - If ld_pending: active duty <= pending, ld_pending <= 0.
  - freq_q/mode_q reload. A mode change restarts with dir = up.
- Duty load:
  - duty_ld copies all CH lanes of duty_i into pending and sets ld_pending.
  - A second duty_ld before the boundary overwrites pending.
  - duty_ld in the same cycle as a boundary: pending gets the new value, ld_pending stays 1, and the transfer happens at the next boundary. Active takes the old pending value this boundary.
- Output comparison:
  - Channel k is registered: pwm_o[k] <= (en & (cnt < duty_act[k])) ^ pol[k].
  - One clk_100m latency from cnt to pwm_o.
  - duty=0 gives constant inactive. duty=2^CW-1 in edge mode gives high for 2^CW-1 of 2^CW steps.
  - 100 % is not reachable; the block does not special-case it.
- en low:
  - ps_cnt and cnt held at 0, dir = up, period_tick = 0.
  - pwm_o = pol, i.e. the inactive level.
  - duty_ld is still accepted.
- en rising:
  - Active duty <= pending immediately if ld_pending (ld_pending cleared).
  - freq_q/mode_q reloaded; counting starts from cnt=0.
- freq or mode changes mid-period have no effect until the boundary, so there are no glitched periods.
- Reset asserted mid-period: outputs go to 0 immediately, regardless of pol. Pending duty is lost.

Test Plan:
1. Edge period: DIV_MAX=2, freq=0, CW=8, duty ch0=64, pol=0, en=1 -> period_tick every 1024 clocks; pwm_o[0] high for 256 clocks then low for 768; cnt_o steps every 4 clocks.
2. Freq sweep: freq 0..7 at DIV_MAX=10, each held for 4 periods (like the existing freq sweep bench) -> tick spacing 262144, 131072, ..., 2048 clocks. A freq change mid-period takes effect only after the next tick.
3. Double buffer:
   - Setup: duty=32 active; pulse duty_ld with 200 at mid-period.
   - Required response: the current period keeps a 32-step high pulse, the next period is 200 steps, ld_pending is 1 until the tick, and duty_ld coincident with a tick defers the load by one period.
4. Centre mode: mode=1, DIV_MAX=0, duty=100 -> period 510 clocks; pwm_o high when cnt<100 on both ramps; pulse centred on cnt=0; tick when cnt 1->0.
5. Polarity/boundaries:
   - Setup: CH=4, duty={0,1,255,128}, pol=4'b0010.
   - Required response: ch0 constant 0; ch1 low 1 step per period; ch2 low 1 step per period; ch3 50 %.
   - With en=0 all outputs equal pol and cnt_o=0.
6. Reset mid-run: assert rst_n=0 at cnt_o=77 with ld_pending=1 -> pwm_o, cnt_o, period_tick, ld_pending all 0 asynchronously. After release with duty 0 and no load, outputs stay inactive.
